csr_req_arbiter: RTL and testbench

CSR_REQ_ARBITER -- requirements
Module: csr_req_arbiter

---
 rtl/csr_req_arbiter_if.sv | 55 +++++
 rtl/csr_req_arbiter.sv | 126 ++++++++++++
 tb/tb_csr_req_arbiter.sv | 292 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/csr_req_arbiter_if.sv
// Bundle of the write/read requester, CSR-side and counter signals of csr_req_arbiter.
// slave is the arbiter's view; master is the view of whoever drives the requests and the CSR block.
interface csr_req_arbiter_if #(
    parameter int unsigned CSR_AW = 16,
    parameter int unsigned CSR_DW = 32
);
    localparam int unsigned CNT_W = 16;

    logic              wr_req_valid_i;
    logic [CSR_AW-1:0] wr_req_addr_i;
    logic [CSR_DW-1:0] wr_req_data_i;
    logic              wr_req_ready_o;
    logic              wr_resp_valid_o;
    logic              wr_resp_error_o;
    logic              wr_resp_ready_i;

    logic              rd_req_valid_i;
    logic [CSR_AW-1:0] rd_req_addr_i;
    logic              rd_req_ready_o;
    logic              rd_resp_valid_o;
    logic [CSR_DW-1:0] rd_resp_data_o;
    logic              rd_resp_error_o;
    logic              rd_resp_ready_i;

    logic              csr_valid_o;
    logic              csr_rd_or_wr_o;
    logic [CSR_AW-1:0] csr_addr_o;
    logic [CSR_DW-1:0] csr_data_o;
    logic              csr_ready_i;
    logic [CSR_DW-1:0] csr_data_i;
    logic              csr_error_i;

    logic [CNT_W-1:0]  wr_cnt_o;
    logic [CNT_W-1:0]  rd_cnt_o;

    modport slave (
        input  wr_req_valid_i, wr_req_addr_i, wr_req_data_i, wr_resp_ready_i,
        input  rd_req_valid_i, rd_req_addr_i, rd_resp_ready_i,
        input  csr_ready_i, csr_data_i, csr_error_i,
        output wr_req_ready_o, wr_resp_valid_o, wr_resp_error_o,
        output rd_req_ready_o, rd_resp_valid_o, rd_resp_data_o, rd_resp_error_o,
        output csr_valid_o, csr_rd_or_wr_o, csr_addr_o, csr_data_o,
        output wr_cnt_o, rd_cnt_o
    );

    modport master (
        output wr_req_valid_i, wr_req_addr_i, wr_req_data_i, wr_resp_ready_i,
        output rd_req_valid_i, rd_req_addr_i, rd_resp_ready_i,
        output csr_ready_i, csr_data_i, csr_error_i,
        input  wr_req_ready_o, wr_resp_valid_o, wr_resp_error_o,
        input  rd_req_ready_o, rd_resp_valid_o, rd_resp_data_o, rd_resp_error_o,
        input  csr_valid_o, csr_rd_or_wr_o, csr_addr_o, csr_data_o,
        input  wr_cnt_o, rd_cnt_o
    );
endinterface

// File: rtl/csr_req_arbiter.sv
// Round-robin arbiter funnelling one write and one read requester onto a single CSR port,
// one transaction in flight, with per-direction completion counters.
module csr_req_arbiter #(
    parameter int unsigned CSR_AW = 16,
    parameter int unsigned CSR_DW = 32
) (
    input logic              clk_axi,
    input logic              arst_axi,
    csr_req_arbiter_if.slave bus
);
    localparam int unsigned CNT_W    = 16;
    localparam logic        GRANT_WR = 1'b1;

    typedef enum logic [1:0] {IDLE, ISSUE, RD_CAPT, RESP} state_t;

    state_t            state_q;
    logic              last_grant_q;
    logic              dir_q;
    logic [CSR_AW-1:0] addr_q;
    logic [CSR_DW-1:0] data_q;
    logic              csr_valid_q;
    logic              wr_resp_valid_q;
    logic              wr_err_q;
    logic              rd_resp_valid_q;
    logic              rd_err_q;
    logic [CSR_DW-1:0] rd_data_q;
    logic [CNT_W-1:0]  wr_cnt_q;
    logic [CNT_W-1:0]  rd_cnt_q;

    logic              wr_win_c;
    logic              rd_win_c;
    logic              idle_c;

    // On a tie the requester that did not win last time is granted.
    assign wr_win_c = bus.wr_req_valid_i & (~bus.rd_req_valid_i | (last_grant_q != GRANT_WR));
    assign rd_win_c = bus.rd_req_valid_i & (~bus.wr_req_valid_i | (last_grant_q == GRANT_WR));
    // Gated by reset so ready cannot leak out while the block is held in reset.
    assign idle_c   = arst_axi & (state_q == IDLE);

    assign bus.wr_req_ready_o  = idle_c & wr_win_c;
    assign bus.rd_req_ready_o  = idle_c & rd_win_c;
    assign bus.wr_resp_valid_o = wr_resp_valid_q;
    assign bus.wr_resp_error_o = wr_err_q;
    assign bus.rd_resp_valid_o = rd_resp_valid_q;
    assign bus.rd_resp_error_o = rd_err_q;
    assign bus.rd_resp_data_o  = rd_data_q;
    assign bus.csr_valid_o     = csr_valid_q;
    assign bus.csr_rd_or_wr_o  = dir_q;
    assign bus.csr_addr_o      = addr_q;
    assign bus.csr_data_o      = data_q;
    assign bus.wr_cnt_o        = wr_cnt_q;
    assign bus.rd_cnt_o        = rd_cnt_q;

    // Transaction FSM with all response and CSR-side outputs registered.
    always_ff @(posedge clk_axi or negedge arst_axi) begin
        if (!arst_axi) begin
            state_q         <= IDLE;
            last_grant_q    <= 1'b0;
            dir_q           <= 1'b0;
            addr_q          <= '0;
            data_q          <= '0;
            csr_valid_q     <= 1'b0;
            wr_resp_valid_q <= 1'b0;
            wr_err_q        <= 1'b0;
            rd_resp_valid_q <= 1'b0;
            rd_err_q        <= 1'b0;
            rd_data_q       <= '0;
            wr_cnt_q        <= '0;
            rd_cnt_q        <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (wr_win_c) begin
                        dir_q        <= 1'b1;
                        addr_q       <= bus.wr_req_addr_i;
                        data_q       <= bus.wr_req_data_i;
                        last_grant_q <= GRANT_WR;
                        rd_data_q    <= '0;
                        csr_valid_q  <= 1'b1;
                        state_q      <= ISSUE;
                    end else if (rd_win_c) begin
                        dir_q        <= 1'b0;
                        addr_q       <= bus.rd_req_addr_i;
                        data_q       <= '0;
                        last_grant_q <= ~GRANT_WR;
                        csr_valid_q  <= 1'b1;
                        state_q      <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (bus.csr_ready_i) begin
                        csr_valid_q <= 1'b0;
                        if (dir_q) begin
                            wr_err_q        <= bus.csr_error_i;
                            wr_resp_valid_q <= 1'b1;
                            state_q         <= RESP;
                        end else begin
                            state_q <= RD_CAPT;
                        end
                    end
                end
                RD_CAPT: begin
                    // CSR read data and error arrive one cycle after the accepted strobe.
                    rd_data_q       <= bus.csr_data_i;
                    rd_err_q        <= bus.csr_error_i;
                    rd_resp_valid_q <= 1'b1;
                    state_q         <= RESP;
                end
                RESP: begin
                    if (dir_q) begin
                        if (bus.wr_resp_ready_i) begin
                            wr_resp_valid_q <= 1'b0;
                            wr_cnt_q        <= wr_cnt_q + CNT_W'(1);
                            state_q         <= IDLE;
                        end
                    end else if (bus.rd_resp_ready_i) begin
                        rd_resp_valid_q <= 1'b0;
                        rd_cnt_q        <= rd_cnt_q + CNT_W'(1);
                        state_q         <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_csr_req_arbiter.sv
// Directed bench for csr_req_arbiter: a vector table of single transactions plus
// hand-written contention, stall, counter-wrap and reset-abort sequences.
module tb_csr_req_arbiter;
    localparam int unsigned AW = 16;
    localparam int unsigned DW = 32;

    typedef struct {
        logic          is_wr;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;      // write data, or CSR read data for reads
        logic          err;
        int            exp_lat;
        logic [DW-1:0] exp_rdata;
        logic          exp_err;
    } vec_t;

    logic clk_axi  = 1'b0;
    logic arst_axi = 1'b0;
    int   checks   = 0;
    int   failures = 0;
    logic [15:0] exp_wr_cnt = '0;
    logic [15:0] exp_rd_cnt = '0;
    vec_t vecs [6];

    always #5 clk_axi = ~clk_axi;

    csr_req_arbiter_if #(.CSR_AW(AW), .CSR_DW(DW)) bus ();

    csr_req_arbiter #(.CSR_AW(AW), .CSR_DW(DW)) dut (
        .clk_axi  (clk_axi),
        .arst_axi (arst_axi),
        .bus      (bus)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_flags"}, 64'({bus.wr_req_ready_o, bus.wr_resp_valid_o, bus.wr_resp_error_o,
                                    bus.rd_req_ready_o, bus.rd_resp_valid_o, bus.rd_resp_error_o,
                                    bus.csr_valid_o, bus.csr_rd_or_wr_o}), 64'd0);
        check({tag, "_csr_addr"}, 64'(bus.csr_addr_o), 64'd0);
        check({tag, "_csr_data"}, 64'(bus.csr_data_o), 64'd0);
        check({tag, "_rd_data"}, 64'(bus.rd_resp_data_o), 64'd0);
        check({tag, "_cnts"}, 64'({bus.wr_cnt_o, bus.rd_cnt_o}), 64'd0);
    endtask

    task automatic idle_inputs();
        bus.wr_req_valid_i  = 1'b0;
        bus.wr_req_addr_i   = '0;
        bus.wr_req_data_i   = '0;
        bus.wr_resp_ready_i = 1'b0;
        bus.rd_req_valid_i  = 1'b0;
        bus.rd_req_addr_i   = '0;
        bus.rd_resp_ready_i = 1'b0;
        bus.csr_ready_i     = 1'b1;
        bus.csr_data_i      = '0;
        bus.csr_error_i     = 1'b0;
    endtask

    // Reset with both valids high so a leaking ready would show up.
    task automatic apply_reset(input string tag);
        @(negedge clk_axi);
        arst_axi = 1'b0;
        bus.wr_req_valid_i = 1'b1;
        bus.rd_req_valid_i = 1'b1;
        #1;
        check_zero(tag);
        idle_inputs();
        @(negedge clk_axi);
        arst_axi   = 1'b1;
        exp_wr_cnt = '0;
        exp_rd_cnt = '0;
    endtask

    // One uncontended transaction; called at a negedge with the DUT in IDLE.
    task automatic run_txn(input vec_t v, input string tag);
        int  lat     = 0;
        int  nstrobe = 0;
        bit  got     = 0;
        bus.csr_ready_i     = 1'b1;
        bus.wr_resp_ready_i = 1'b1;
        bus.rd_resp_ready_i = 1'b1;
        if (v.is_wr) begin
            bus.wr_req_valid_i = 1'b1;
            bus.wr_req_addr_i  = v.addr;
            bus.wr_req_data_i  = v.data;
        end else begin
            bus.rd_req_valid_i = 1'b1;
            bus.rd_req_addr_i  = v.addr;
        end
        #1;
        check({tag, "_ready"}, 64'({bus.wr_req_ready_o, bus.rd_req_ready_o}), 64'({v.is_wr, ~v.is_wr}));
        @(negedge clk_axi);
        bus.wr_req_valid_i = 1'b0;
        bus.rd_req_valid_i = 1'b0;
        for (int cyc = 1; cyc <= 12 && !got; cyc++) begin
            // Error/data are wrong in every cycle except the one the DUT should sample.
            if (v.is_wr) begin
                bus.csr_error_i = (cyc == 1) ? v.err : ~v.err;
                bus.csr_data_i  = 32'h0BAD_0BAD;
            end else begin
                bus.csr_error_i = (cyc == 2) ? v.err : ~v.err;
                bus.csr_data_i  = (cyc == 2) ? v.data : 32'h0BAD_0BAD;
            end
            #1;
            if (bus.csr_valid_o) begin
                nstrobe++;
                if (cyc == 1) begin
                    check({tag, "_csr_dir"}, 64'(bus.csr_rd_or_wr_o), 64'(v.is_wr));
                    check({tag, "_csr_addr"}, 64'(bus.csr_addr_o), 64'(v.addr));
                    if (v.is_wr) check({tag, "_csr_data"}, 64'(bus.csr_data_o), 64'(v.data));
                end
            end
            if (bus.wr_resp_valid_o || bus.rd_resp_valid_o) begin
                got = 1;
                lat = cyc;
                check({tag, "_resp_kind"}, 64'({bus.wr_resp_valid_o, bus.rd_resp_valid_o}),
                      64'({v.is_wr, ~v.is_wr}));
                check({tag, "_resp_err"}, 64'(v.is_wr ? bus.wr_resp_error_o : bus.rd_resp_error_o),
                      64'(v.exp_err));
                check({tag, "_resp_data"}, 64'(bus.rd_resp_data_o), 64'(v.exp_rdata));
            end
            @(negedge clk_axi);
        end
        check({tag, "_latency"}, 64'(lat), 64'(v.exp_lat));
        check({tag, "_strobes"}, 64'(nstrobe), 64'd1);
        if (v.is_wr) exp_wr_cnt = exp_wr_cnt + 16'd1;
        else         exp_rd_cnt = exp_rd_cnt + 16'd1;
        #1;
        check({tag, "_resp_done"}, 64'({bus.wr_resp_valid_o, bus.rd_resp_valid_o}), 64'd0);
        check({tag, "_cnts"}, 64'({bus.wr_cnt_o, bus.rd_cnt_o}), 64'({exp_wr_cnt, exp_rd_cnt}));
        bus.wr_resp_ready_i = 1'b0;
        bus.rd_resp_ready_i = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        vecs[0] = '{1'b1, 16'h1010, 32'hA5A5_A5A5, 1'b0, 2, 32'h0000_0000, 1'b0};
        vecs[1] = '{1'b0, 16'h1000, 32'hDEAD_0001, 1'b0, 3, 32'hDEAD_0001, 1'b0};
        vecs[2] = '{1'b1, 16'h0004, 32'h1234_5678, 1'b1, 2, 32'h0000_0000, 1'b1};
        vecs[3] = '{1'b0, 16'h0008, 32'hCAFE_F00D, 1'b1, 3, 32'hCAFE_F00D, 1'b1};
        vecs[4] = '{1'b0, 16'hFFFF, 32'h0000_0000, 1'b0, 3, 32'h0000_0000, 1'b0};
        vecs[5] = '{1'b1, 16'hFFFF, 32'hFFFF_FFFF, 1'b0, 2, 32'h0000_0000, 1'b0};

        idle_inputs();
        apply_reset("reset0");

        for (int i = 0; i < 6; i++) run_txn(vecs[i], $sformatf("vec%0d", i));

        // Stalled write: strobe held 6 cycles, error sampled only on the accepting cycle.
        begin
            bus.csr_ready_i    = 1'b0;
            bus.csr_error_i    = 1'b0;
            bus.wr_req_valid_i = 1'b1;
            bus.wr_req_addr_i  = 16'h2222;
            bus.wr_req_data_i  = 32'h3333_4444;
            @(negedge clk_axi);
            bus.wr_req_valid_i = 1'b0;
            for (int c = 1; c <= 6; c++) begin
                if (c == 6) begin
                    bus.csr_ready_i = 1'b1;
                    bus.csr_error_i = 1'b1;
                end
                #1;
                check($sformatf("stall_c%0d", c), 64'({bus.csr_valid_o, bus.csr_rd_or_wr_o,
                      bus.csr_addr_o, bus.csr_data_o, bus.wr_req_ready_o}),
                      64'({1'b1, 1'b1, 16'h2222, 32'h3333_4444, 1'b0}));
                @(negedge clk_axi);
            end
            bus.csr_error_i = 1'b0;
            #1;
            check("stall_resp", 64'({bus.csr_valid_o, bus.wr_resp_valid_o, bus.wr_resp_error_o}),
                  64'({1'b0, 1'b1, 1'b1}));
            bus.wr_resp_ready_i = 1'b1;
            @(negedge clk_axi);
            bus.wr_resp_ready_i = 1'b0;
            exp_wr_cnt = exp_wr_cnt + 16'd1;
            #1;
            check("stall_cnt", 64'(bus.wr_cnt_o), 64'(exp_wr_cnt));
        end

        // Contention: both valid from reset, expected grants W, R, W, R with held responses.
        apply_reset("reset1");
        bus.wr_req_valid_i = 1'b1;
        bus.wr_req_addr_i  = 16'h0A0A;
        bus.wr_req_data_i  = 32'h1111_2222;
        bus.rd_req_valid_i = 1'b1;
        bus.rd_req_addr_i  = 16'h0B0B;
        for (int k = 0; k < 4; k++) begin
            logic          exp_w;
            logic          seen;
            logic [DW-1:0] exp_d;
            exp_w = (k % 2 == 0);
            exp_d = exp_w ? 32'h0 : (32'h5151_0000 + 32'(k));
            bus.csr_data_i = 32'h5151_0000 + 32'(k);
            seen = 1'b0;
            for (int n = 0; n < 10 && !seen; n++) begin
                @(negedge clk_axi);
                #1;
                seen = bus.csr_valid_o;
            end
            check($sformatf("arb%0d_grant", k), 64'({seen, bus.csr_rd_or_wr_o}), 64'({1'b1, exp_w}));
            seen = 1'b0;
            for (int n = 0; n < 10 && !seen; n++) begin
                @(negedge clk_axi);
                #1;
                seen = bus.wr_resp_valid_o | bus.rd_resp_valid_o;
            end
            for (int h = 1; h <= 3; h++) begin
                @(negedge clk_axi);
                #1;
                check($sformatf("arb%0d_hold%0d", k, h), 64'({bus.wr_resp_valid_o, bus.rd_resp_valid_o,
                      bus.rd_resp_data_o, bus.wr_req_ready_o, bus.rd_req_ready_o}),
                      64'({exp_w, ~exp_w, exp_d, 1'b0, 1'b0}));
            end
            if (exp_w) bus.wr_resp_ready_i = 1'b1;
            else       bus.rd_resp_ready_i = 1'b1;
            @(negedge clk_axi);
            #1;
            bus.wr_resp_ready_i = 1'b0;
            bus.rd_resp_ready_i = 1'b0;
            check($sformatf("arb%0d_done", k), 64'({bus.wr_resp_valid_o, bus.rd_resp_valid_o}), 64'd0);
        end
        check("arb_cnts", 64'({bus.wr_cnt_o, bus.rd_cnt_o}), 64'({16'd2, 16'd2}));
        @(negedge clk_axi);
        idle_inputs();
        apply_reset("reset2");

        // Counter wrap: preload near the top, then two writes roll it through 0xFFFF to 0.
        dut.wr_cnt_q = 16'hFFFE;
        exp_wr_cnt   = 16'hFFFE;
        run_txn(vecs[0], "wrap1");
        run_txn(vecs[0], "wrap2");
        check("wrap_zero", 64'(bus.wr_cnt_o), 64'd0);

        // Reset while the write strobe is stalled: csr_valid_o must drop without a clock edge.
        bus.csr_ready_i    = 1'b0;
        bus.wr_req_valid_i = 1'b1;
        bus.wr_req_addr_i  = 16'h7777;
        bus.wr_req_data_i  = 32'h8888_9999;
        @(negedge clk_axi);
        bus.wr_req_valid_i = 1'b0;
        #1;
        check("abort_issue_pre", 64'(bus.csr_valid_o), 64'd1);
        #1;
        arst_axi = 1'b0;
        #1;
        check_zero("abort_issue");
        @(negedge clk_axi);
        idle_inputs();
        arst_axi = 1'b1;

        // Reset during RD_CAPT: no read response may appear after release.
        bus.rd_req_valid_i = 1'b1;
        bus.rd_req_addr_i  = 16'h4444;
        bus.csr_data_i     = 32'h7E57_7E57;
        @(negedge clk_axi);
        bus.rd_req_valid_i = 1'b0;
        @(negedge clk_axi);
        #2;
        arst_axi = 1'b0;
        #1;
        check_zero("abort_rdcapt");
        @(negedge clk_axi);
        arst_axi = 1'b1;
        bus.rd_resp_ready_i = 1'b0;
        begin
            int stray = 0;
            for (int n = 0; n < 6; n++) begin
                @(negedge clk_axi);
                #1;
                if (bus.rd_resp_valid_o || bus.csr_valid_o) stray++;
            end
            check("abort_no_resp", 64'(stray), 64'd0);
        end
        check("abort_cnts", 64'({bus.wr_cnt_o, bus.rd_cnt_o}), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
